// File: rtl/debug_burst_pkg.sv
// debug_burst_pkg: FSM encoding, debug register map and STATUS bit layout shared by debug_burst_regs.
package debug_burst_pkg;

    typedef enum logic [1:0] {S_IDLE, S_RD_BURST, S_WR_BURST, S_SINGLE} state_e;

    localparam logic [7:0] A_ADDR_LO = 8'h10;
    localparam logic [7:0] A_ADDR_HI = 8'h11;
    localparam logic [7:0] A_CE_CTRL = 8'h12;
    localparam logic [7:0] A_LEN     = 8'h13;
    localparam logic [7:0] A_CTRL    = 8'h14;
    localparam logic [7:0] A_BUF     = 8'h20;
    localparam logic [7:0] A_SINGLE  = 8'h21;

    localparam int CTRL_RD  = 0;
    localparam int CTRL_WR  = 1;
    localparam int CTRL_CLR = 2;

    localparam int ST_OVF   = 15;
    localparam int ST_UNF   = 14;
    localparam int ST_START = 13;
    localparam int ST_BUSY  = 12;

endpackage

// File: rtl/debug_word_buf.sv
// debug_word_buf: 2**AW x 16-bit two-pointer FIFO with first-word-fall-through head output.
module debug_word_buf #(
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [15:0]   data_i,
    output logic [15:0]   data_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   count_o
);

    localparam int DEPTH = 2**AW;
    localparam int CW    = AW + 1;

    logic [15:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push, do_pop;

    assign full_o  = count_q == CW'(DEPTH);
    assign empty_o = count_q == '0;
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/debug_burst_regs.sv
// debug_burst_regs: debug register file bridging the debug ctrl bus to the QSPI arbiter debug port,
// with buffered multi-word bursts, blocking single-word access and sticky error flags.
module debug_burst_regs
    import debug_burst_pkg::*;
#(
    parameter int CHIP_SELECTS = 2,
    parameter int ADDR_W       = 24,
    parameter int BUF_AW       = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              dbg_a,
    input  logic [15:0]             dbg_di,
    output logic [15:0]             dbg_do,
    input  logic                    dbg_we,
    input  logic                    dbg_rd,
    output logic                    dbg_ready,
    output logic [ADDR_W-1:0]       debug_addr,
    input  logic [15:0]             debug_rdata,
    output logic [15:0]             debug_wdata,
    output logic [1:0]              debug_wstrb,
    output logic                    debug_valid,
    input  logic                    debug_ready,
    input  logic                    debug_xfer_done,
    output logic [3:0]              debug_xfer_len,
    output logic [CHIP_SELECTS-1:0] debug_ce_ctrl,
    output logic                    busy
);

    localparam int         BUF_DEPTH = 2**BUF_AW;
    localparam logic [3:0] LEN_MAX   = 4'(BUF_DEPTH - 1);

    state_e                  state_q, state_d;
    logic [ADDR_W-1:0]       addr_q, addr_d, burst_step;
    logic [CHIP_SELECTS-1:0] ce_q, ce_d;
    logic [3:0]              len_q, len_d;
    logic                    ovf_q, ovf_d, unf_q, unf_d, start_q, start_d;
    logic                    we_q, rd_q, we_f, rd_f, idle;
    logic                    buf_push, buf_pop, buf_full, buf_empty;
    logic [15:0]             buf_wdata, buf_rdata;
    logic [BUF_AW:0]         count;
    logic [31:0]             addr_ext;

    debug_word_buf #(.AW(BUF_AW)) u_buf (
        .clk     (clk),
        .rst     (rst),
        .push_i  (buf_push),
        .pop_i   (buf_pop),
        .data_i  (buf_wdata),
        .data_o  (buf_rdata),
        .full_o  (buf_full),
        .empty_o (buf_empty),
        .count_o (count)
    );

    assign idle          = state_q == S_IDLE;
    assign busy          = !idle;
    assign we_f          = dbg_we && !we_q;
    assign rd_f          = dbg_rd && !rd_q;
    assign addr_ext      = 32'(addr_q);
    assign burst_step    = ADDR_W'({len_q, 1'b0}) + ADDR_W'(2);
    assign debug_addr    = addr_q;
    assign debug_ce_ctrl = ce_q;

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        ce_d           = ce_q;
        len_d          = len_q;
        ovf_d          = ovf_q;
        unf_d          = unf_q;
        start_d        = start_q;
        buf_push       = 1'b0;
        buf_pop        = 1'b0;
        buf_wdata      = dbg_di;
        dbg_ready      = dbg_we || dbg_rd;
        dbg_do         = '0;
        debug_valid    = 1'b0;
        debug_wdata    = '0;
        debug_wstrb    = 2'b00;
        debug_xfer_len = '0;
        if (we_f) begin
            case (dbg_a)
                A_ADDR_LO: if (idle) addr_d[15:0] = dbg_di;
                A_ADDR_HI: if (idle) addr_d = ADDR_W'({dbg_di, addr_q[15:0]});
                A_CE_CTRL: if (idle) ce_d = dbg_di[CHIP_SELECTS-1:0];
                A_LEN:     if (idle) len_d = (dbg_di[3:0] > LEN_MAX) ? LEN_MAX : dbg_di[3:0];
                A_CTRL: begin
                    if (dbg_di[CTRL_CLR]) {ovf_d, unf_d, start_d} = 3'b000;
                    if (dbg_di[CTRL_RD] && dbg_di[CTRL_WR]) start_d = 1'b1;
                    else if (dbg_di[CTRL_RD]) begin
                        if (idle && count == '0) state_d = S_RD_BURST;
                        else start_d = 1'b1;
                    end else if (dbg_di[CTRL_WR]) begin
                        if (idle && 5'(count) >= 5'(len_q) + 5'd1) state_d = S_WR_BURST;
                        else start_d = 1'b1;
                    end
                end
                A_BUF: begin
                    buf_push = idle && !buf_full;
                    ovf_d    = ovf_q || !(idle && !buf_full);
                end
                default: ;
            endcase
        end
        if (rd_f && dbg_a == A_BUF) begin
            buf_pop = idle && !buf_empty;
            unf_d   = unf_q || !(idle && !buf_empty);
        end
        if (dbg_rd) begin
            case (dbg_a)
                A_ADDR_LO: dbg_do = addr_ext[15:0];
                A_ADDR_HI: dbg_do = addr_ext[31:16];
                A_CE_CTRL: dbg_do = 16'(ce_q);
                A_LEN:     dbg_do = {12'b0, len_q};
                A_CTRL:    dbg_do = {ovf_q, unf_q, start_q, busy, 7'b0, 5'(count)};
                A_BUF:     dbg_do = (idle && !buf_empty) ? buf_rdata : 16'h0000;
                default:   dbg_do = '0;
            endcase
        end
        // A fresh 0x21 strobe in IDLE blocks the master until the arbiter completes the word
        if (idle && (we_f || rd_f) && dbg_a == A_SINGLE) begin
            state_d   = S_SINGLE;
            dbg_ready = 1'b0;
        end
        case (state_q)
            S_IDLE: ;
            S_RD_BURST: begin
                debug_valid    = 1'b1;
                debug_xfer_len = len_q;
                buf_wdata      = debug_rdata;
                buf_push       = debug_ready;
                if (debug_xfer_done) begin
                    state_d = S_IDLE;
                    addr_d  = addr_q + burst_step;
                end
            end
            S_WR_BURST: begin
                debug_valid    = 1'b1;
                debug_xfer_len = len_q;
                debug_wdata    = buf_rdata;
                debug_wstrb    = 2'b11;
                buf_pop        = debug_ready;
                if (debug_xfer_done) begin
                    state_d = S_IDLE;
                    addr_d  = addr_q + burst_step;
                end
            end
            S_SINGLE: begin
                debug_valid = (dbg_we || dbg_rd) && !debug_ready;
                debug_wdata = dbg_di;
                debug_wstrb = dbg_we ? 2'b11 : 2'b00;
                dbg_ready   = debug_ready;
                dbg_do      = dbg_rd ? debug_rdata : 16'h0000;
                if (debug_ready) begin
                    state_d = S_IDLE;
                    addr_d  = addr_q + ADDR_W'(2);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            ce_q    <= CHIP_SELECTS'(1);
            len_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            start_q <= 1'b0;
            we_q    <= 1'b0;
            rd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            ce_q    <= ce_d;
            len_q   <= len_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            start_q <= start_d;
            we_q    <= dbg_we;
            rd_q    <= dbg_rd;
        end
    end

endmodule

// File: tb/tb_debug_burst_regs.sv
// tb_debug_burst_regs: directed scoreboard bench for debug_burst_regs; stimulus queues expected
// debug read data and QSPI write words, a negedge monitor pops and compares them.
module tb_debug_burst_regs;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  dbg_a = '0;
    logic [15:0] dbg_di = '0;
    logic [15:0] dbg_do;
    logic        dbg_we = 1'b0;
    logic        dbg_rd = 1'b0;
    logic        dbg_ready;
    logic [23:0] debug_addr;
    logic [15:0] debug_rdata = '0;
    logic [15:0] debug_wdata;
    logic [1:0]  debug_wstrb;
    logic        debug_valid;
    logic        debug_ready = 1'b0;
    logic        debug_xfer_done = 1'b0;
    logic [3:0]  debug_xfer_len;
    logic [1:0]  debug_ce_ctrl;
    logic        busy;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] rq[$];
    logic [15:0] wq[$];

    debug_burst_regs #(.CHIP_SELECTS(2), .ADDR_W(24), .BUF_AW(3)) dut (
        .clk             (clk),
        .rst             (rst),
        .dbg_a           (dbg_a),
        .dbg_di          (dbg_di),
        .dbg_do          (dbg_do),
        .dbg_we          (dbg_we),
        .dbg_rd          (dbg_rd),
        .dbg_ready       (dbg_ready),
        .debug_addr      (debug_addr),
        .debug_rdata     (debug_rdata),
        .debug_wdata     (debug_wdata),
        .debug_wstrb     (debug_wstrb),
        .debug_valid     (debug_valid),
        .debug_ready     (debug_ready),
        .debug_xfer_done (debug_xfer_done),
        .debug_xfer_len  (debug_xfer_len),
        .debug_ce_ctrl   (debug_ce_ctrl),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    // Monitor: every completed debug read and every QSPI write word is matched against the queues
    always @(negedge clk) begin
        if (!rst && dbg_rd && dbg_ready) begin
            if (rq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected: got %h with no expected value queued", dbg_do);
            end else check("dbg_do", 32'(dbg_do), 32'(rq.pop_front()));
        end
        if (!rst && debug_valid && debug_ready && debug_wstrb != 2'b00) begin
            check("wstrb", 32'(debug_wstrb), 32'h3);
            if (wq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wr_unexpected: got %h with no expected word queued", debug_wdata);
            end else check("debug_wdata", 32'(debug_wdata), 32'(wq.pop_front()));
        end
    end

    task automatic reg_wr(input logic [7:0] a, input logic [15:0] d);
        @(posedge clk); #1;
        dbg_a = a; dbg_di = d; dbg_we = 1'b1;
        @(posedge clk); #1;
        dbg_we = 1'b0;
    endtask

    task automatic reg_rd(input logic [7:0] a, input logic [15:0] exp);
        @(posedge clk); #1;
        rq.push_back(exp);
        dbg_a = a; dbg_rd = 1'b1;
        @(posedge clk); #1;
        dbg_rd = 1'b0;
    endtask

    task automatic serve(input int n, input logic [15:0] base, input logic [3:0] len);
        int t = 0;
        while (!debug_valid && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        check("valid_seen", 32'(debug_valid), 32'h1);
        check("xfer_len", 32'(debug_xfer_len), 32'(len));
        for (int i = 0; i < n; i++) begin
            debug_rdata = base + 16'(i);
            debug_ready = 1'b1;
            debug_xfer_done = (i == n - 1);
            @(posedge clk); #1;
            debug_ready = 1'b0;
            debug_xfer_done = 1'b0;
        end
        check("valid_after_done", 32'(debug_valid), 32'h0);
        check("busy_after_done", 32'(busy), 32'h0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(debug_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_wstrb", 32'(debug_wstrb), 32'h0);
        check("rst_xfer_len", 32'(debug_xfer_len), 32'h0);
        check("rst_dbg_do", 32'(dbg_do), 32'h0);
        rst = 1'b0;
        reg_rd(8'h12, 16'h0001);
        reg_rd(8'h13, 16'h0000);
        reg_rd(8'h14, 16'h0000);
        reg_wr(8'h13, 16'h000F);
        reg_rd(8'h13, 16'h0007);
        reg_rd(8'h55, 16'h0000);

        // read burst of 4 words
        reg_wr(8'h10, 16'h0100);
        reg_wr(8'h11, 16'h0000);
        reg_wr(8'h13, 16'h0003);
        reg_wr(8'h14, 16'h0001);
        serve(4, 16'h00A0, 4'd3);
        for (int i = 0; i < 4; i++) reg_rd(8'h20, 16'h00A0 + 16'(i));
        reg_rd(8'h10, 16'h0108);
        reg_rd(8'h11, 16'h0000);
        reg_rd(8'h14, 16'h0000);

        // write burst of 2 words
        reg_wr(8'h20, 16'h0011);
        reg_wr(8'h20, 16'h0022);
        reg_wr(8'h13, 16'h0001);
        wq.push_back(16'h0011);
        wq.push_back(16'h0022);
        reg_wr(8'h14, 16'h0002);
        serve(2, 16'h0000, 4'd1);
        reg_rd(8'h10, 16'h010C);
        reg_rd(8'h14, 16'h0000);

        // illegal starts
        reg_wr(8'h20, 16'h0033);
        reg_wr(8'h20, 16'h0044);
        reg_wr(8'h13, 16'h0003);
        reg_wr(8'h14, 16'h0002);
        check("illegal_valid", 32'(debug_valid), 32'h0);
        check("illegal_busy", 32'(busy), 32'h0);
        reg_rd(8'h14, 16'h2002);
        reg_wr(8'h14, 16'h0004);
        reg_rd(8'h14, 16'h0002);
        reg_wr(8'h14, 16'h0003);
        check("both_valid", 32'(debug_valid), 32'h0);
        reg_rd(8'h14, 16'h2002);
        reg_wr(8'h14, 16'h0004);
        reg_rd(8'h20, 16'h0033);
        reg_rd(8'h20, 16'h0044);
        reg_rd(8'h14, 16'h0000);

        // overflow and underflow
        for (int i = 1; i <= 9; i++) reg_wr(8'h20, 16'(i));
        reg_rd(8'h14, 16'h8008);
        for (int i = 1; i <= 8; i++) reg_rd(8'h20, 16'(i));
        reg_rd(8'h20, 16'h0000);
        reg_rd(8'h14, 16'hC000);
        reg_wr(8'h14, 16'h0004);
        reg_rd(8'h14, 16'h0000);

        // single access with address wrap
        reg_wr(8'h10, 16'hFFFE);
        reg_wr(8'h11, 16'h00FF);
        reg_rd(8'h11, 16'h00FF);
        @(posedge clk); #1;
        rq.push_back(16'hBEEF);
        dbg_a = 8'h21; dbg_rd = 1'b1;
        @(posedge clk); #1;
        check("single_valid", 32'(debug_valid), 32'h1);
        check("single_len", 32'(debug_xfer_len), 32'h0);
        debug_rdata = 16'hBEEF;
        debug_ready = 1'b1;
        @(posedge clk); #1;
        debug_ready = 1'b0;
        dbg_rd = 1'b0;
        check("single_addr", 32'(debug_addr), 32'h0);
        reg_rd(8'h10, 16'h0000);
        reg_rd(8'h11, 16'h0000);

        // reset in the middle of a read burst
        reg_wr(8'h12, 16'h0002);
        reg_wr(8'h13, 16'h0002);
        reg_wr(8'h14, 16'h0001);
        check("mid_valid", 32'(debug_valid), 32'h1);
        debug_rdata = 16'h5555;
        debug_ready = 1'b1;
        @(posedge clk); #1;
        debug_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_busy", 32'(busy), 32'h0);
        check("rst_mid_valid", 32'(debug_valid), 32'h0);
        rst = 1'b0;
        reg_rd(8'h14, 16'h0000);
        reg_rd(8'h12, 16'h0001);

        repeat (3) @(posedge clk);
        check("rq_drained", 32'(rq.size()), 32'h0);
        check("wq_drained", 32'(wq.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
